alu_mc: RTL and testbench
=========================

Name: alu_mc

Overview:
- Parametrised, multi-cycle successor to the core datapath ALU, sitting between the decode stage and the register-file writeback.
- Keeps the existing 4-bit opcode map and the stateful carry / shift-overflow semantics, generalised to WIDTH bits.
- Adds a valid/ready input handshake, a registered result with out_valid, a multi-cycle shift-add multiplier with a high-word register, and a sticky halt state.

Parameters:
- WIDTH, 8, datapath width in bits (>= 4).
- SHW, $clog2(WIDTH)+1, width of the internal saturated shift amount and the multiply iteration counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  op1/op2/operation are valid this cycle.
- in_ready  out  1  block can accept an operation this cycle.
- op1  in  WIDTH  first operand.
- op2  in  WIDTH  second operand / shift amount / jump target.
- operation  in  4  opcode.
- result  out  WIDTH  registered result.
- out_valid  out  1  one-cycle pulse: result holds the newly completed operation.
- carry  out  1  registered carry flag.
- jump  out  1  pulses with out_valid for opcode 14.
- exit  out  1  sticky halt indicator.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; result=0, out_valid=0, carry=0, sho=0, hi=0, jump=0, exit=0.
  - Iteration counter=0; in_ready=1.
  - Reset asserted mid-multiply aborts it immediately; no out_valid.
- States and ready:
  - States are IDLE, MUL and HALT.
  - in_ready = (state==IDLE), decoded combinationally from state.
  - An operation is accepted on a rising edge where in_valid & in_ready.
- Single-cycle opcodes:
  - Accepted on edge k; result and flags update on edge k; out_valid=1 for the cycle after edge k.
  - Back-to-back accepts every cycle are allowed.
  - Without an accept, out_valid=0 and result holds its value.
- Opcode map (shift amount s = min(op2, WIDTH); all arithmetic is mod 2^WIDTH):
  - 0 add: result=op1+op2; carry=carry-out.
  - 1 rshift: result=op1>>s, logical; sho unchanged.
  - 2 lshift: result=op1<<s. sho=op1>>(WIDTH-s) for s>0, sho=0 for s=0; s=WIDTH gives result=0, sho=op1.
  - 3 or: result=op1|op2.
  - 4 and: result=op1&op2.
  - 5, 6 set-op2: result=op2.
  - 7 mul: multi-cycle (see Optional Feature).
  - 8 bitwise negation: result=~op1.
  - 9 logical negation: result=(op1==0), zero-extended.
  - 10 sho: result=sho.
  - 11 adc: result=op1+carry; carry=carry-out.
  - 12 exit: result unchanged; exit=1; state->HALT.
  - 13 nop: result unchanged; out_valid still pulses.
  - 14 jump: result=op2; jump=1 alongside out_valid.
  - 15 mulhi: result=hi.
- Flag ownership:
  - Only opcodes 0 and 11 write carry.
  - Only opcode 2 writes sho.
  - hi is written only by mul completion.
- HALT:
  - Entered one edge after the exit op is accepted; out_valid pulses once for the exit op.
  - Thereafter in_ready=0 and inputs are ignored until reset.

Optional Feature:
- MULT_EN defined:
  - Opcode 7 is accepted on edge k and latches op1/op2; state->MUL, in_ready=0.
  - Edges k+1..k+WIDTH each perform one shift-add iteration into a 2*WIDTH accumulator.
  - On edge k+WIDTH: result=product[WIDTH-1:0], hi=product[2*WIDTH-1:WIDTH], state->IDLE.
  - out_valid=1 in the cycle after edge k+WIDTH.
  - Flags carry and sho are unchanged; in_valid during MUL is ignored.
- MULT_EN undefined:
  - Opcodes 7 and 15 behave exactly as nop.
  - The MUL state, counter, accumulator and hi register are not built.

Test Plan:
- Reset then add 0+3 -> result=3, out_valid one cycle, carry=0. Then add 255+3 -> result=2, carry=1. Then adc op1=255 -> 0, carry=1. Then adc op1=128 -> 129, carry=0.
- lshift 0x30 by 3 -> 0x80; sho op -> 1. lshift 0x81 by 8 (WIDTH=8) -> 0; sho -> 0x81. rshift 128 by 3 -> 16 with sho unchanged.
- Back-to-back single-cycle stream, in_valid held high: or 0xDD|0x3C -> 0xFD, and -> 0x1C, bitwise negation 0xDD -> 0x22, logical negation 0 -> 1 -> out_valid high 4 consecutive cycles.
- MULT_EN: mul 200*3 -> in_ready low for 8 cycles, result=0x58 with out_valid 8 cycles after accept. Then mulhi -> 0x02. in_valid pulsed during MUL is ignored.
- Assert rst_n low during MUL iteration 4 -> result=0, in_ready=1, no out_valid. A following add 1+1 -> 2.
- jump op2=0x40 -> result=0x40, jump and out_valid pulse together, carry unchanged. Then exit -> exit=1 sticky, in_ready=0, later add ignored until reset.

Source files
------------

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with valid/ready input, registered result/flags and a sticky halt.
// Build option: define MULT_EN to include the shift-add multiplier (opcode 7) and its high word (opcode 15).
module alu_mc #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic [3:0]       operation,
  output logic [WIDTH-1:0] result,
  output logic             out_valid,
  output logic             carry,
  output logic             jump,
  output logic             exit
);
  // state | meaning
  // IDLE  | accepting one operation per cycle
  // MUL   | shift-add multiply in progress, inputs ignored
  // HALT  | exit executed, inputs ignored until reset
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t             state;
  logic [WIDTH-1:0]   sho;
  logic [SHW-1:0]     shamt;
  logic [2*WIDTH-1:0] shl;
  logic [WIDTH-1:0]   nxt_result;
  logic [WIDTH-1:0]   nxt_sho;
  logic               nxt_carry;

`ifdef MULT_EN
  logic [WIDTH-1:0]   hi;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_nxt;
  logic [SHW-1:0]     cnt;

  assign acc_nxt = mplier[0] ? (acc + mcand) : acc;
`endif

  assign in_ready = (state == IDLE);

  // Saturate the shift amount so a WIDTH-bit shift still moves op1 entirely into sho.
  assign shamt = (op2 >= WIDTH'(WIDTH)) ? SHW'(WIDTH) : SHW'(op2);
  assign shl   = {{WIDTH{1'b0}}, op1} << shamt;

  always_comb begin
    nxt_result = result;
    nxt_carry  = carry;
    nxt_sho    = sho;
    case (operation)
      4'd0:              {nxt_carry, nxt_result} = {1'b0, op1} + {1'b0, op2};
      4'd1:              nxt_result = op1 >> shamt;
      4'd2:              {nxt_sho, nxt_result} = shl;
      4'd3:              nxt_result = op1 | op2;
      4'd4:              nxt_result = op1 & op2;
      4'd5, 4'd6, 4'd14: nxt_result = op2;
      4'd8:              nxt_result = ~op1;
      4'd9:              nxt_result = {{(WIDTH-1){1'b0}}, (op1 == '0)};
      4'd10:             nxt_result = sho;
      4'd11:             {nxt_carry, nxt_result} = {1'b0, op1} + {{WIDTH{1'b0}}, carry};
`ifdef MULT_EN
      4'd15:             nxt_result = hi;
`endif
      default:           ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      result    <= '0;
      out_valid <= 1'b0;
      carry     <= 1'b0;
      sho       <= '0;
      jump      <= 1'b0;
      exit      <= 1'b0;
`ifdef MULT_EN
      hi        <= '0;
      mplier    <= '0;
      mcand     <= '0;
      acc       <= '0;
      cnt       <= '0;
`endif
    end else begin
      out_valid <= 1'b0;
      jump      <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
`ifdef MULT_EN
            if (operation == 4'd7) begin
              mcand  <= {{WIDTH{1'b0}}, op1};
              mplier <= op2;
              acc    <= '0;
              cnt    <= SHW'(WIDTH);
              state  <= MUL;
            end else
`endif
            begin
              result    <= nxt_result;
              carry     <= nxt_carry;
              sho       <= nxt_sho;
              out_valid <= 1'b1;
              jump      <= (operation == 4'd14);
              if (operation == 4'd12) begin
                exit  <= 1'b1;
                state <= HALT;
              end
            end
          end
        end
`ifdef MULT_EN
        MUL: begin
          acc    <= acc_nxt;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt - SHW'(1);
          if (cnt == SHW'(1)) begin
            result    <= acc_nxt[WIDTH-1:0];
            hi        <= acc_nxt[2*WIDTH-1:WIDTH];
            out_valid <= 1'b1;
            state     <= IDLE;
          end
        end
`endif
        HALT:    state <= HALT;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc: directed scenarios plus random ops against an arithmetic reference model.
module tb_alu_mc;
  localparam int W = 8;
  localparam longint MASK = (longint'(1) << W) - 1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] op1 = '0;
  logic [W-1:0] op2 = '0;
  logic [3:0]   operation = '0;
  logic [W-1:0] result;
  logic         out_valid;
  logic         carry;
  logic         jump;
  logic         exit;

  alu_mc #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op1(op1), .op2(op2), .operation(operation), .result(result),
    .out_valid(out_valid), .carry(carry), .jump(jump), .exit(exit)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [W-1:0] res;
    logic         c;
    logic         j;
  } exp_t;

  exp_t   q[$];
  int     checks = 0;
  int     errors = 0;
  int     ov_run = 0;
  int     max_run = 0;
  int     last_ov_cyc = 0;
  int     last_acc_cyc = 0;
  longint m_res = 0, m_carry = 0, m_sho = 0, m_hi = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: applies one accepted operation and queues the response it must produce.
  function automatic void model_push(input int op, input longint a, input longint b);
    longint t;
    longint s;
    logic   j;
    j = 1'b0;
    s = (b > W) ? W : b;
    case (op)
      0:  begin t = a + b; m_res = t & MASK; m_carry = t >> W; end
      1:  m_res = a >> s;
      2:  begin t = a << s; m_res = t & MASK; m_sho = (t >> W) & MASK; end
      3:  m_res = a | b;
      4:  m_res = a & b;
      5, 6: m_res = b;
      8:  m_res = (~a) & MASK;
      9:  m_res = (a == 0) ? 1 : 0;
      10: m_res = m_sho;
      11: begin t = a + m_carry; m_res = t & MASK; m_carry = t >> W; end
      14: begin m_res = b; j = 1'b1; end
`ifdef MULT_EN
      7:  begin t = a * b; m_res = t & MASK; m_hi = t >> W; end
      15: m_res = m_hi;
`endif
      default: ;
    endcase
    q.push_back('{res: W'(m_res), c: m_carry[0], j: j});
  endfunction

  task automatic issue(input int op, input longint a, input longint b);
    int g;
    g = 0;
    while (!in_ready && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: in_ready=%0b, expected 1 within 100 cycles", in_ready);
      return;
    end
    in_valid  = 1'b1;
    operation = 4'(op);
    op1       = W'(a);
    op2       = W'(b);
    model_push(op, a, b);
    @(negedge clk);
    last_acc_cyc = cyc;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (q.size() != 0 && g < 300) begin
      @(negedge clk);
      g++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d responses outstanding, expected 0", q.size());
      q.delete();
    end
    @(negedge clk);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a result.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (out_valid) begin
          ov_run++;
          if (ov_run > max_run) max_run = ov_run;
          last_ov_cyc = cyc;
          checks++;
          if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_out_valid: got result=0x%0h with no operation pending", result);
          end else begin
            e = q.pop_front();
            if (result !== e.res || carry !== e.c || jump !== e.j) begin
              errors++;
              $display("FAIL scoreboard: got result=0x%0h carry=%0b jump=%0b, expected result=0x%0h carry=%0b jump=%0b",
                       result, carry, jump, e.res, e.c, e.j);
            end
          end
        end else begin
          ov_run = 0;
          if (jump) begin
            checks++;
            errors++;
            $display("FAIL jump_without_valid: got jump=1, expected 0");
          end
        end
      end
    end
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int lowc;
    int cnt;
    int op;
    longint a, b;

    repeat (2) @(negedge clk);
    chk("reset_result", result, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_carry", carry, 0);
    chk("reset_jump", jump, 0);
    chk("reset_exit", exit, 0);
    chk("reset_in_ready", in_ready, 1);
    rst_n = 1'b1;
    @(negedge clk);

    // add / adc carry chain
    issue(0, 0, 3);
    issue(0, 255, 3);
    issue(11, 255, 0);
    issue(11, 128, 0);
    drain();
    chk("adc_result", result, 129);
    chk("adc_carry", carry, 0);

    // shifts and the sho register, including the full-width boundary
    issue(2, 'h30, 3);
    issue(10, 0, 0);
    issue(2, 'h81, 8);
    issue(10, 0, 0);
    issue(1, 128, 3);
    issue(10, 0, 0);
    drain();
    chk("sho_after_rshift", result, 'h81);

    // back-to-back stream with in_valid held high
    max_run = 0;
    issue(3, 'hDD, 'h3C);
    issue(4, 'hDD, 'h3C);
    issue(8, 'hDD, 0);
    issue(9, 0, 0);
    drain();
    chk("b2b_out_valid_run", max_run, 4);

`ifdef MULT_EN
    issue(7, 200, 3);
    lowc = 0;
    while (!in_ready && lowc < 50) begin
      if (lowc < 3) begin
        in_valid = 1'b1; operation = 4'd0; op1 = 8'd1; op2 = 8'd1;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      lowc++;
    end
    in_valid = 1'b0;
    chk("mul_busy_cycles", lowc, W);
    drain();
    chk("mul_latency", last_ov_cyc - last_acc_cyc, W);
    issue(15, 0, 0);
    drain();

    // reset during the fourth multiply iteration
    issue(7, $urandom_range(1, 255), $urandom_range(1, 255));
    repeat (3) @(negedge clk);
`else
    issue(0, 5, 6);
    drain();
`endif
    rst_n = 1'b0;
    #1;
    chk("midreset_result", result, 0);
    chk("midreset_in_ready", in_ready, 1);
    chk("midreset_out_valid", out_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    q.delete();
    m_res = 0; m_carry = 0; m_sho = 0; m_hi = 0;
    cnt = 0;
    repeat (W + 2) begin
      @(negedge clk);
      if (out_valid) cnt++;
    end
    chk("midreset_no_out_valid", cnt, 0);
    issue(0, 1, 1);
    drain();

    // jump keeps carry
    issue(0, 255, 3);
    issue(14, 'h12, 'h40);
    drain();

    for (int i = 0; i < 300; i++) begin
      op = $urandom_range(0, 15);
      if (op == 12) op = 13;
      a = $urandom_range(0, 255);
      b = $urandom_range(0, 255);
      if ((op == 1 || op == 2) && $urandom_range(0, 1) == 1) b = $urandom_range(0, W + 2);
      issue(op, a, b);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end
    drain();

    // exit is sticky and blocks further operations
    issue(0, 7, 9);
    issue(12, 1, 2);
    drain();
    chk("exit_set", exit, 1);
    chk("halt_in_ready", in_ready, 0);
    in_valid = 1'b1; operation = 4'd0; op1 = 8'd1; op2 = 8'd1;
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) cnt++;
    end
    in_valid = 1'b0;
    chk("halt_ignored_out_valid", cnt, 0);
    chk("halt_result_hold", result, m_res);
    chk("exit_sticky", exit, 1);
    chk("halt_in_ready_sticky", in_ready, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
